// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage and the decode stage that consumes IF/ID.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  // Opcode/funct values decoded downstream.
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus, pipeline control requests and IF/ID outputs of the fetch stage.
interface instruction_fetch_unit_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             stall;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic             halted;
  logic             align_err;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall, flush, redirect_valid, redirect_pc,
    output if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
    output halted, align_err, fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall, flush, redirect_valid, redirect_pc,
    input  if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid,
    input  halted, align_err, fetch_count
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load captures a new word, flush alone clears only the valid bit.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_plus4_reg;
  logic        valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg    <= NOP_INSTR;
      pc_reg       <= 32'd0;
      pc_plus4_reg <= INSTR_BYTES;
      valid_reg    <= 1'b0;
    end else if (load) begin
      instr_reg    <= instr_in;
      pc_reg       <= pc_in;
      pc_plus4_reg <= pc_in + INSTR_BYTES;
      valid_reg    <= !flush;
    end else if (flush) begin
      valid_reg    <= 1'b0;
    end
  end

  assign instr    = instr_reg;
  assign pc       = pc_reg;
  assign pc_plus4 = pc_plus4_reg;
  assign valid    = valid_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, RUN/HALT/ERR control and fetched-instruction counter,
// feeding the IF/ID register from a combinational instruction memory.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PROG_END = 32'd360,
  parameter int          CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);

  localparam fetch_state_t RESET_STATE = (RESET_PC < PROG_END) ? RUN : HALT;

  fetch_state_t     state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             load;
  logic             kill;
  logic             count_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      pc_reg    <= RESET_PC;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  // kill clears IF/ID valid; with load it turns the captured word into a bubble.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    load       = 1'b0;
    kill       = 1'b0;
    count_inc  = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.redirect_valid) begin
          kill = 1'b1;
          if (is_aligned(bus.redirect_pc[1:0])) pc_next = bus.redirect_pc;
          else                                  state_next = ERR;
        end else if (bus.stall) begin
          kill = bus.flush;
        end else if (pc_reg >= PROG_END) begin
          state_next = HALT;
          kill       = 1'b1;
        end else begin
          load      = 1'b1;
          kill      = bus.flush;
          pc_next   = pc_reg + INSTR_BYTES;
          count_inc = !bus.flush;
        end
      end
      HALT: begin
        kill = 1'b1;
        if (bus.redirect_valid) begin
          if (is_aligned(bus.redirect_pc[1:0])) begin
            pc_next    = bus.redirect_pc;
            state_next = (bus.redirect_pc < PROG_END) ? RUN : HALT;
          end else begin
            state_next = ERR;
          end
        end
      end
      default: kill = 1'b1;
    endcase
  end

  // Saturating: the counter sticks at all-ones rather than wrapping to zero.
  always_comb begin
    count_next = count_reg;
    if (count_inc && (count_reg != '1)) count_next = count_reg + CNT_W'(1);
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .flush    (kill),
    .instr_in (bus.imem_data),
    .pc_in    (pc_reg),
    .instr    (bus.if_id_instr),
    .pc       (bus.if_id_pc),
    .pc_plus4 (bus.if_id_pc_plus4),
    .valid    (bus.if_id_valid)
  );

  assign bus.imem_addr   = pc_reg;
  assign bus.halted      = (state_reg == HALT);
  assign bus.align_err   = (state_reg == ERR);
  assign bus.fetch_count = count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a cycle-by-cycle reference model.
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] PROG_END = 32'd360;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_unit_if #(.CNT_W(16)) bus ();

  instruction_fetch_unit #(
    .RESET_PC (32'd0),
    .PROG_END (PROG_END),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Program image: two fixed loads at 0 and 4, then LW/SW words tagged with their address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= PROG_END) return 32'hDEAD_BEEF;
    if (a == 32'd0) return 32'h8E08_0200;
    if (a == 32'd4) return 32'h8E09_0300;
    return {(a[2] ? OP_SW : OP_LW), 10'h0A5, a[15:0]};
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = running, 1 = halted, 2 = alignment error.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc;
  logic        m_valid;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0; m_pc <= 32'd0; m_instr <= 32'd0; m_ifpc <= 32'd0;
      m_valid <= 1'b0; m_cnt <= 16'd0;
    end else if (m_mode == 0) begin
      if (bus.redirect_valid) begin
        m_valid <= 1'b0;
        if (bus.redirect_pc % 4 != 0) m_mode <= 2;
        else m_pc <= bus.redirect_pc;
      end else if (bus.stall) begin
        if (bus.flush) m_valid <= 1'b0;
      end else if (m_pc >= PROG_END) begin
        m_mode <= 1; m_valid <= 1'b0;
      end else begin
        m_instr <= mem_word(m_pc);
        m_ifpc  <= m_pc;
        m_pc    <= m_pc + 32'd4;
        m_valid <= !bus.flush;
        if (!bus.flush && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
      end
    end else if (m_mode == 1) begin
      m_valid <= 1'b0;
      if (bus.redirect_valid) begin
        if (bus.redirect_pc % 4 != 0) m_mode <= 2;
        else begin
          m_pc   <= bus.redirect_pc;
          m_mode <= (bus.redirect_pc < PROG_END) ? 0 : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("imem_addr", bus.imem_addr, m_pc);
    check("if_id_valid", 32'(bus.if_id_valid), 32'(m_valid));
    check("if_id_instr", bus.if_id_instr, m_instr);
    check("if_id_pc", bus.if_id_pc, m_ifpc);
    check("if_id_pc_plus4", bus.if_id_pc_plus4, m_ifpc + 32'd4);
    check("halted", 32'(bus.halted), 32'(m_mode == 1));
    check("align_err", 32'(bus.align_err), 32'(m_mode == 2));
    check("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_addr(input logic [31:0] target);
    int n = 0;
    while (bus.imem_addr != target && n < 200) begin
      tick();
      n++;
    end
    check("reach_addr", bus.imem_addr, target);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0] frozen;

  initial begin
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_imem_addr", bus.imem_addr, 32'd0);
    check("rst_pc_plus4", bus.if_id_pc_plus4, 32'd4);
    check("rst_valid", 32'(bus.if_id_valid), 32'd0);
    #9 rst_n = 1'b1;

    tick();
    $display("fetch 1: pc=%0d instr=%h valid=%0d", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid);
    check("first_instr", bus.if_id_instr, 32'h8E08_0200);
    check("first_pc", bus.if_id_pc, 32'd0);
    check("first_valid", 32'(bus.if_id_valid), 32'd1);
    tick();
    $display("fetch 2: pc=%0d instr=%h", bus.if_id_pc, bus.if_id_instr);
    check("second_instr", bus.if_id_instr, 32'h8E09_0300);
    check("second_pc", bus.if_id_pc, 32'd4);

    run_until_addr(32'd24);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("stall %0d: addr=%0d if_id_pc=%0d", i, bus.imem_addr, bus.if_id_pc);
      check("stall_addr", bus.imem_addr, 32'd24);
      check("stall_ifpc", bus.if_id_pc, 32'd20);
    end
    bus.stall = 1'b0;
    tick();
    check("after_stall_pc", bus.if_id_pc, 32'd24);
    check("after_stall_instr", bus.if_id_instr, 32'h8CA5_0018);

    run_until_addr(32'd40);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd120;
    tick();
    bus.redirect_valid = 1'b0;
    $display("redirect: addr=%0d valid=%0d", bus.imem_addr, bus.if_id_valid);
    check("redir_bubble", 32'(bus.if_id_valid), 32'd0);
    check("redir_addr", bus.imem_addr, 32'd120);
    tick();
    check("redir_target_pc", bus.if_id_pc, 32'd120);
    check("redir_target_instr", bus.if_id_instr, 32'h8CA5_0078);

    bus.flush = 1'b1;
    tick();
    bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0; bus.stall = 1'b0;
    $display("flush+stall: addr=%0d valid=%0d", bus.imem_addr, bus.if_id_valid);
    check("flush_stall_addr", bus.imem_addr, 32'd128);
    tick();

    reset_pulse();
    begin
      int n = 0;
      while (!(bus.if_id_valid && bus.if_id_pc == 32'd356) && n < 200) begin
        tick();
        n++;
      end
    end
    check("last_pc", bus.if_id_pc, 32'd356);
    check("last_instr", bus.if_id_instr, 32'hACA5_0164);
    tick();
    $display("halt: halted=%0d valid=%0d count=%0d", bus.halted, bus.if_id_valid, bus.fetch_count);
    check("halt_flag", 32'(bus.halted), 32'd1);
    check("halt_count", 32'(bus.fetch_count), 32'd90);
    bus.stall = 1'b1; bus.flush = 1'b1;
    tick();
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd400;
    tick();
    check("halt_redir_high", bus.imem_addr, 32'd400);
    bus.redirect_pc = 32'd0;
    tick();
    bus.redirect_valid = 1'b0;
    check("resume_halted", 32'(bus.halted), 32'd0);
    tick();
    check("resume_pc", bus.if_id_pc, 32'd0);
    check("resume_count", 32'(bus.fetch_count), 32'd91);

    tick(); tick();
    frozen = bus.imem_addr;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd42;
    tick();
    $display("misaligned: align_err=%0d addr=%0d", bus.align_err, bus.imem_addr);
    check("align_err", 32'(bus.align_err), 32'd1);
    check("err_frozen", bus.imem_addr, frozen);
    bus.redirect_pc = 32'd0; bus.stall = 1'b1;
    tick(); tick();
    bus.redirect_valid = 1'b0; bus.stall = 1'b0;
    check("err_ignored", bus.imem_addr, frozen);
    reset_pulse();
    check("err_cleared", 32'(bus.align_err), 32'd0);

    repeat (5) tick();
    bus.stall = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'd8;
    tick();
    bus.stall = 1'b0; bus.redirect_valid = 1'b0;
    check("stall_redir_pc", bus.imem_addr, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: addr=%0d valid=%0d count=%0d", bus.imem_addr, bus.if_id_valid, bus.fetch_count);
    check("async_pc", bus.imem_addr, 32'd0);
    check("async_valid", 32'(bus.if_id_valid), 32'd0);
    check("async_count", 32'(bus.fetch_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
